// File: rtl/mem_loader.sv
// mem_loader: accepts framed bytes (0xA5, ADDR, COUNT, data) and writes 32-bit words to core DMEM.
// Define MEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before a frame completes.
module mem_loader #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_SYNC,
    S_ADDR,
    S_CNT,
    S_DATA,
    S_WRITE,
`ifdef MEM_LOADER_CHECKSUM_EN
    S_DONE,
    S_CSUM
`else
    S_DONE
`endif
  } state_t;

  state_t        state;
  logic [31:0]   base_addr;
  logic [15:0]   word_cnt;
  logic [15:0]   index;
  logic [23:0]   word;
  logic [1:0]    byte_idx;
  logic [TW-1:0] idle;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  logic accept;
  logic in_frame;
  logic timeout;

  assign accept   = byte_valid && byte_ready;
  assign in_frame = (state == S_ADDR) || (state == S_CNT) || (state == S_DATA);
  // Timeout fires on the TIMEOUT_CYCLES-th consecutive edge without an accepted byte.
  assign timeout  = in_frame && !accept && (idle == IDLE_LAST);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_SYNC;
      byte_ready <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      base_addr  <= '0;
      word_cnt   <= '0;
      index      <= '0;
      word       <= '0;
      byte_idx   <= '0;
      idle       <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      // Write strobe and bus are single-cycle; ready is only withheld in WRITE and DONE.
      byte_ready <= 1'b1;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      idle       <= (in_frame && !accept) ? idle + 1'b1 : '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      if (accept && in_frame) csum <= csum ^ byte_data;
`endif

      case (state)
        S_SYNC: begin
          if (accept && byte_data == SYNC_BYTE) begin
            state      <= S_ADDR;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
            byte_idx   <= '0;
            index      <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end

        S_ADDR: begin
          if (timeout) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            byte_idx <= '0;
            state    <= S_SYNC;
          end else if (accept) begin
            base_addr[8*byte_idx +: 8] <= byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (base_addr[1:0] != 2'b00) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= S_SYNC;
              end else begin
                state <= S_CNT;
              end
            end
          end
        end

        S_CNT: begin
          if (timeout) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            byte_idx <= '0;
            state    <= S_SYNC;
          end else if (accept) begin
            if (byte_idx == 2'd0) begin
              word_cnt[7:0] <= byte_data;
              byte_idx      <= 2'd1;
            end else begin
              word_cnt[15:8] <= byte_data;
              byte_idx       <= '0;
              if ({byte_data, word_cnt[7:0]} == 16'd0) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                state <= S_CSUM;
`else
                state      <= S_DONE;
                busy       <= 1'b0;
                done       <= 1'b1;
                core_rst_n <= 1'b1;
                byte_ready <= 1'b0;
`endif
              end else begin
                state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (timeout) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            byte_idx <= '0;
            state    <= S_SYNC;
          end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word[7:0]   <= byte_data;
              2'd1: word[15:8]  <= byte_data;
              2'd2: word[23:16] <= byte_data;
              default: begin
                state      <= S_WRITE;
                dmem_we    <= 1'b1;
                dmem_addr  <= base_addr + {14'd0, index, 2'b00};
                dmem_wdata <= {byte_data, word};
                byte_ready <= 1'b0;
              end
            endcase
          end
        end

        S_WRITE: begin
          index <= index + 16'd1;
          if (index + 16'd1 == word_cnt) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            state <= S_CSUM;
`else
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            core_rst_n <= 1'b1;
            byte_ready <= 1'b0;
`endif
          end else begin
            state <= S_DATA;
          end
        end

`ifdef MEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (byte_data == csum) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
              byte_ready <= 1'b0;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_SYNC;
            end
          end
        end
`endif

        S_DONE: state <= S_SYNC;

        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed frames; expected DMEM writes are queued and checked by a separate monitor.
module tb_mem_loader;

  localparam int T = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         writes_seen = 0;
  int         w0;
  logic [7:0] tb_csum;

  mem_loader #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && dmem_we) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got 0x%08h@0x%08h expected no write", dmem_wdata, dmem_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", dmem_addr, e.addr);
        check("write_data", dmem_wdata, e.data);
      end
    end
  end

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      check("ready_wait", 32'(byte_ready), 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    tb_csum    = tb_csum ^ b;
  endtask

  task automatic send_hdr(input logic [31:0] addr, input logic [15:0] cnt);
    send_byte(8'hA5);
    tb_csum = 8'h00;
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
    wr_t e;
    e.addr = addr;
    e.data = w;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_csum();
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(tb_csum);
`endif
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(done || err) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) check({name, "_end_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_dmem_we",    32'(dmem_we),    32'd0);
    check("rst_dmem_addr",  dmem_addr,       32'd0);
    check("rst_dmem_wdata", dmem_wdata,      32'd0);
    check("rst_flags", {28'd0, core_rst_n, busy, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(byte_ready), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    tb_csum    = 8'h00;
    repeat (3) @(negedge clk);
    pulse_reset();

    // Basic two-word frame.
    w0 = writes_seen;
    send_hdr(32'h0000_1000, 16'd2);
    check("busy_in_frame",     32'(busy),       32'd1);
    check("core_held_in_frame", 32'(core_rst_n), 32'd0);
    send_word(32'h0000_1000, 32'h4433_2211);
    send_word(32'h0000_1004, 32'h8877_6655);
    send_csum();
    wait_end("basic");
    check("basic_flags", {29'd0, core_rst_n, done, err}, 32'b110);
    check("basic_busy", 32'(busy), 32'd0);
    check("basic_writes", writes_seen - w0, 32'd2);

    // Garbage before sync is ignored.
    w0 = writes_seen;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_hdr(32'h0000_1000, 16'd2);
    send_word(32'h0000_1000, 32'h4433_2211);
    send_word(32'h0000_1004, 32'h8877_6655);
    send_csum();
    wait_end("garbage");
    check("garbage_flags", {29'd0, core_rst_n, done, err}, 32'b110);
    check("garbage_writes", writes_seen - w0, 32'd2);

    // Misaligned address aborts with no writes.
    w0 = writes_seen;
    send_hdr(32'h0000_1002, 16'd2);
    wait_end("misaligned");
    check("misaligned_flags", {29'd0, core_rst_n, done, err}, 32'b001);
    check("misaligned_busy", 32'(busy), 32'd0);
    check("misaligned_writes", writes_seen - w0, 32'd0);

    // Address wrap past 0xFFFFFFFC, with 0xA5 bytes carried as data.
    w0 = writes_seen;
    send_hdr(32'hFFFF_FFFC, 16'd2);
    send_word(32'hFFFF_FFFC, 32'hA5A5_A5A5);
    send_word(32'h0000_0000, 32'hDEAD_BEEF);
    send_csum();
    wait_end("wrap");
    check("wrap_flags", {29'd0, core_rst_n, done, err}, 32'b110);
    check("wrap_writes", writes_seen - w0, 32'd2);

    // COUNT=0 completes without a write.
    w0 = writes_seen;
    send_hdr(32'hFFFF_FFFC, 16'd0);
    send_csum();
    wait_end("count0");
    check("count0_flags", {29'd0, core_rst_n, done, err}, 32'b110);
    check("count0_writes", writes_seen - w0, 32'd0);

    // Idle for TIMEOUT_CYCLES-1 cycles mid-word: no error.
    w0 = writes_seen;
    send_hdr(32'h0000_3000, 16'd1);
    exp_q.push_back('{addr: 32'h0000_3000, data: 32'h0403_0201});
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (T - 1) @(negedge clk);
    check("near_timeout_err", 32'(err), 32'd0);
    send_byte(8'h03);
    send_byte(8'h04);
    send_csum();
    wait_end("near_timeout");
    check("near_timeout_flags", {29'd0, core_rst_n, done, err}, 32'b110);
    check("near_timeout_writes", writes_seen - w0, 32'd1);

    // Idle for TIMEOUT_CYCLES cycles mid-word: abort, core stays held.
    w0 = writes_seen;
    send_hdr(32'h0000_2000, 16'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (T) @(negedge clk);
    check("timeout_flags", {29'd0, core_rst_n, done, err}, 32'b001);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_writes", writes_seen - w0, 32'd0);

    // Reset between the two writes: second write never happens.
    w0 = writes_seen;
    send_hdr(32'h0000_1000, 16'd2);
    send_word(32'h0000_1000, 32'h4433_2211);
    send_byte(8'h55);
    pulse_reset();
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    repeat (4) @(negedge clk);
    check("midreset_writes", writes_seen - w0, 32'd1);
    check("midreset_flags", {28'd0, core_rst_n, busy, done, err}, 32'd0);

    // Loader recovers after reset.
    w0 = writes_seen;
    send_hdr(32'h0000_0040, 16'd1);
    send_word(32'h0000_0040, 32'h1234_5678);
    send_csum();
    wait_end("recover");
    check("recover_flags", {29'd0, core_rst_n, done, err}, 32'b110);
    check("recover_writes", writes_seen - w0, 32'd1);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
